// File: rtl/lsu_defs_pkg.sv
// lsu_defs: shared encodings for the LSU data port.
//   - access size codes (SZ_BYTE / SZ_HALF / SZ_WORD; 2'b11 is reserved)
//   - FSM state encoding for lsu_data_port
//   - lane geometry (MASK_WIDTH byte lanes of LANE_W bits)
package lsu_defs;

  localparam int MASK_WIDTH = 4;
  localparam int LANE_W     = 8;
  localparam int WORD_W     = MASK_WIDTH * LANE_W;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for a 32-bit data port.
//   size_i/addr_lo_i/unsigned_i : access descriptor (size code, byte offset, zero-extend)
//   wdata_i -> wdata_o           : right-aligned store data shifted into its lanes
//   rdata_i -> rdata_o           : cache word, lane extracted and sign/zero extended
//   mask_o                       : byte-lane enables, bit i = byte i
//   fault_o                      : misaligned half/word or reserved size
module lsu_lane_align
  import lsu_defs::*;
(
  input  logic [1:0]            size_i,
  input  logic [1:0]            addr_lo_i,
  input  logic                  unsigned_i,
  input  logic [WORD_W-1:0]     wdata_i,
  input  logic [WORD_W-1:0]     rdata_i,
  output logic [MASK_WIDTH-1:0] mask_o,
  output logic [WORD_W-1:0]     wdata_o,
  output logic [WORD_W-1:0]     rdata_o,
  output logic                  fault_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    // Aligned halves only ever sit at offset 0 or 2.
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    wdata_o  = wdata_i << {addr_lo_i, 3'b000};
    mask_o   = '0;
    rdata_o  = '0;
    fault_o  = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        mask_o  = 4'b0001 << addr_lo_i;
        rdata_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        mask_o  = 4'b0011 << addr_lo_i;
        fault_o = addr_lo_i[0];
        rdata_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        mask_o  = 4'b1111;
        fault_o = |addr_lo_i;
        rdata_o = rdata_i;
      end
      default: fault_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_data_port.sv
// lsu_data_port: pipeline-side initiator for the cached memory data port.
// Takes one load/store at a time, drives a held read/write enable with a
// word-aligned address, byte mask and lane-shifted data until the cache
// reports the matching done, then returns one response pulse.
//   clk, rst (sync, active-high)
//   req_*        : pipeline request (valid/ready handshake, ready only in IDLE)
//   resp_*       : one-cycle response with extended load data / fault flag
//   busy         : FSM not idle
//   proc_data_*  : cache data-port handshake, address, mask, data
//   stat_*       : load/store/wait counters, live only with LSU_STATS_EN
//                  defined, otherwise tied to 0
module lsu_data_port
  import lsu_defs::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int STAT_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_is_store,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_fault,
  output logic                     busy,
  output logic                     proc_data_read_enable,
  output logic                     proc_data_write_enable,
  input  logic                     proc_data_read_done,
  input  logic                     proc_data_write_done,
  output logic [ADDRESS_WIDTH-1:0] proc_data_address,
  output logic [MASK_WIDTH-1:0]    proc_mask_vector,
  output logic [DATA_WIDTH-1:0]    proc_data_write,
  input  logic [DATA_WIDTH-1:0]    proc_data_read,
  output logic [STAT_WIDTH-1:0]    stat_loads,
  output logic [STAT_WIDTH-1:0]    stat_stores,
  output logic [STAT_WIDTH-1:0]    stat_wait_cycles
);

  lsu_state_e                 state_q;
  logic                       is_store_q, uns_q, rd_en_q, wr_en_q;
  logic                       resp_valid_q, fault_q;
  logic [1:0]                 size_q, lo_q;
  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic [MASK_WIDTH-1:0]      mask_q;
  logic [DATA_WIDTH-1:0]      wdata_q, rdata_q;

  // One aligner serves both directions: in IDLE it sees the incoming request
  // (mask, shift, fault); afterwards it sees the registered descriptor so the
  // load extract uses the captured offset/size.
  logic                       idle;
  logic [1:0]                 al_size, al_lo;
  logic                       al_uns, al_fault;
  logic [MASK_WIDTH-1:0]      al_mask;
  logic [DATA_WIDTH-1:0]      al_wdata, al_rdata;
  logic                       done_match;

  assign idle    = (state_q == ST_IDLE);
  assign al_size = idle ? req_size     : size_q;
  assign al_lo   = idle ? req_addr[1:0] : lo_q;
  assign al_uns  = idle ? req_unsigned : uns_q;

  lsu_lane_align u_align (
    .size_i     (al_size),
    .addr_lo_i  (al_lo),
    .unsigned_i (al_uns),
    .wdata_i    (req_wdata),
    .rdata_i    (proc_data_read),
    .mask_o     (al_mask),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata),
    .fault_o    (al_fault)
  );

  // Only the done matching the operation counts; the other is ignored.
  assign done_match = is_store_q ? proc_data_write_done : proc_data_read_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      is_store_q   <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= '0;
      lo_q         <= '0;
      addr_q       <= '0;
      mask_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid) begin
          is_store_q <= req_is_store;
          uns_q      <= req_unsigned;
          size_q     <= req_size;
          lo_q       <= req_addr[1:0];
          addr_q     <= {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
          mask_q     <= al_mask;
          wdata_q    <= al_wdata;
          if (al_fault) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            fault_q      <= 1'b1;
            rdata_q      <= '0;
          end else begin
            state_q <= ST_ACCESS;
            rd_en_q <= ~req_is_store;
            wr_en_q <= req_is_store;
          end
        end
        ST_ACCESS: if (done_match) begin
          state_q      <= ST_RESP;
          rd_en_q      <= 1'b0;
          wr_en_q      <= 1'b0;
          resp_valid_q <= 1'b1;
          rdata_q      <= is_store_q ? '0 : al_rdata;
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          fault_q      <= 1'b0;
          rdata_q      <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready              = idle;
  assign busy                   = ~idle;
  assign resp_valid             = resp_valid_q;
  assign resp_rdata             = rdata_q;
  assign resp_fault             = fault_q;
  assign proc_data_read_enable  = rd_en_q;
  assign proc_data_write_enable = wr_en_q;
  assign proc_data_address      = addr_q;
  assign proc_mask_vector       = mask_q;
  assign proc_data_write        = wdata_q;

`ifdef LSU_STATS_EN
  logic [STAT_WIDTH-1:0] loads_q, stores_q, wait_q;

  // Saturating counters; a completed access is a RESP cycle without fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      loads_q  <= '0;
      stores_q <= '0;
      wait_q   <= '0;
    end else begin
      if (state_q == ST_RESP && !fault_q) begin
        if (!is_store_q && loads_q != '1)  loads_q  <= loads_q + 1'b1;
        if (is_store_q  && stores_q != '1) stores_q <= stores_q + 1'b1;
      end
      if (state_q == ST_ACCESS && wait_q != '1) wait_q <= wait_q + 1'b1;
    end
  end

  assign stat_loads       = loads_q;
  assign stat_stores      = stores_q;
  assign stat_wait_cycles = wait_q;
`else
  assign stat_loads       = '0;
  assign stat_stores      = '0;
  assign stat_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_lsu_data_port.sv
// Directed bench for lsu_data_port. Cycle 0 is the cycle a request is
// presented; outputs are sampled 1ns after each rising edge.
module tb_lsu_data_port;
  import lsu_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault, busy;
  logic [31:0] resp_rdata;
  logic        rd_en, wr_en, rd_done, wr_done;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic [3:0]  p_mask;
  logic [31:0] st_ld, st_st, st_wait;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  lsu_data_port dut (
    .clk                    (clk),
    .rst                    (rst),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_is_store           (req_is_store),
    .req_size               (req_size),
    .req_unsigned           (req_unsigned),
    .req_addr               (req_addr),
    .req_wdata              (req_wdata),
    .resp_valid             (resp_valid),
    .resp_rdata             (resp_rdata),
    .resp_fault             (resp_fault),
    .busy                   (busy),
    .proc_data_read_enable  (rd_en),
    .proc_data_write_enable (wr_en),
    .proc_data_read_done    (rd_done),
    .proc_data_write_done   (wr_done),
    .proc_data_address      (p_addr),
    .proc_mask_vector       (p_mask),
    .proc_data_write        (p_wdata),
    .proc_data_read         (p_rdata),
    .stat_loads             (st_ld),
    .stat_stores            (st_st),
    .stat_wait_cycles       (st_wait)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Normal access: matching done arrives 3 cycles after the enable (cycle 4),
  // a stray non-matching done is pulsed in cycle 2.
  task automatic run_op(input string tag, input logic st, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rword, input logic [31:0] e_addr,
                        input logic [3:0] e_mask, input logic [31:0] e_wd,
                        input logic [31:0] e_rd);
    chk({tag, ".ready0"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    tick();                                             // cycle 1
    req_valid = 1'b0; req_wdata = 32'h5A5A_5A5A; req_addr = 32'hFFFF_FFFF;
    chk({tag, ".en"},   {30'd0, rd_en, wr_en}, {30'd0, ~st, st});
    chk({tag, ".addr"}, p_addr, e_addr);
    chk({tag, ".mask"}, {28'd0, p_mask}, {28'd0, e_mask});
    chk({tag, ".wdat"}, p_wdata, e_wd);
    chk({tag, ".busy"}, {30'd0, busy, req_ready}, 32'd2);
    tick();                                             // cycle 2
    if (st) rd_done = 1'b1; else wr_done = 1'b1;
    tick();                                             // cycle 3
    rd_done = 1'b0; wr_done = 1'b0;
    chk({tag, ".hold"}, {29'd0, rd_en, wr_en, resp_valid}, {29'd0, ~st, st, 1'b0});
    chk({tag, ".haddr"}, p_addr, e_addr);
    tick();                                             // cycle 4
    rd_done = 1'b1; wr_done = 1'b1; p_rdata = rword;
    tick();                                             // cycle 5
    rd_done = 1'b0; wr_done = 1'b0; p_rdata = 32'hDEAD_0000;
    chk({tag, ".rv"},  {28'd0, resp_valid, resp_fault, rd_en, wr_en}, 32'h8);
    chk({tag, ".rd"},  resp_rdata, e_rd);
    chk({tag, ".rdy"}, {31'd0, req_ready}, 32'd0);
    tick();                                             // cycle 6
    chk({tag, ".end"}, {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  task automatic run_fault(input string tag, input logic st, input logic [1:0] sz,
                           input logic [31:0] addr);
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = 1'b0;
    req_addr = addr; req_wdata = 32'h1111_2222;
    rd_done = 1'b1; wr_done = 1'b1; p_rdata = 32'hFFFF_FFFF;
    tick();                                             // cycle 1
    req_valid = 1'b0;
    chk({tag, ".rsp"}, {28'd0, resp_valid, resp_fault, rd_en, wr_en}, 32'hC);
    chk({tag, ".rd"},  resp_rdata, 32'd0);
    chk({tag, ".rdy"}, {31'd0, req_ready}, 32'd0);
    tick();                                             // cycle 2
    rd_done = 1'b0; wr_done = 1'b0;
    chk({tag, ".end"}, {27'd0, resp_valid, resp_fault, rd_en, wr_en, req_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size = SZ_WORD;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    rd_done = 1'b0; wr_done = 1'b0; p_rdata = '0;
    tick(); tick();
    chk("rst.ctl",  {26'd0, req_ready, busy, resp_valid, resp_fault, rd_en, wr_en}, 32'h20);
    chk("rst.addr", p_addr, 32'd0);
    chk("rst.mask", {28'd0, p_mask}, 32'd0);
    chk("rst.wdat", p_wdata, 32'd0);
    chk("rst.rd",   resp_rdata, 32'd0);
    chk("rst.stat", st_ld | st_st | st_wait, 32'd0);
    rst = 1'b0;
    tick();

    run_op("sw",  1'b1, SZ_WORD, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,
           32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    run_op("lb",  1'b0, SZ_BYTE, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_1234,
           32'h0000_0100, 4'b1000, 32'h0, 32'hFFFF_FF80);
    run_op("lbu", 1'b0, SZ_BYTE, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_1234,
           32'h0000_0100, 4'b1000, 32'h0, 32'h0000_0080);
    run_op("sh",  1'b1, SZ_HALF, 1'b0, 32'h0000_0202, 32'h5555_ABCD, 32'h0,
           32'h0000_0200, 4'b1100, 32'hABCD_0000, 32'h0);
    run_op("lhu", 1'b0, SZ_HALF, 1'b1, 32'h0000_0206, 32'h0, 32'h80FF_1234,
           32'h0000_0204, 4'b1100, 32'h0, 32'h0000_80FF);

    run_fault("lw_mis", 1'b0, SZ_WORD, 32'h0000_0101);
    run_fault("ld_rsv", 1'b0, 2'b11,   32'h0000_0100);
    run_fault("sh_mis", 1'b1, SZ_HALF, 32'h0000_0201);

`ifdef LSU_STATS_EN
    chk("stat.ld",   st_ld,   32'd3);
    chk("stat.st",   st_st,   32'd2);
    chk("stat.wait", st_wait, 32'd20);
`else
    chk("stat.ld",   st_ld,   32'd0);
    chk("stat.st",   st_st,   32'd0);
    chk("stat.wait", st_wait, 32'd0);
`endif

    // Reset while a load is outstanding, then a late done.
    req_valid = 1'b1; req_is_store = 1'b0; req_size = SZ_WORD; req_addr = 32'h0000_0300;
    tick();
    req_valid = 1'b0;
    chk("mid.en", {31'd0, rd_en}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid.rst", {28'd0, rd_en, wr_en, req_ready, busy}, 32'h2);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("mid.late", {28'd0, resp_valid, rd_en, req_ready, busy}, 32'h2);
    tick();
    chk("mid.quiet", {29'd0, resp_valid, rd_en, req_ready}, 32'h1);
    chk("mid.stat",  st_ld | st_st | st_wait, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
